// File: rtl/cim_pkg.sv
// Shared width helpers, defaults and beat framing for the CIM accumulate tree.
package cim_pkg;

    localparam int N_BANKS_DEF = 16;
    localparam int DIN_W_DEF   = 8;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic neg;
    } beat_ctl_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic int tree_w(input int n, input int din);
        return din + clog2(n);
    endfunction

    function automatic int acc_w(input int n, input int din, input int act);
        return tree_w(n, din) + act + 1;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain W-bit adder used at every node of the reduction tree.
module adder_nbit #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/cim_accum_tree.sv
// Bank reduction tree plus MSB-first bit-plane shift accumulator.
// Define CIM_TREE_PIPE_EN to register every tree level (latency 2 + LEVELS).
module cim_accum_tree
    import cim_pkg::*;
#(
    parameter int N_BANKS  = N_BANKS_DEF,
    parameter int DIN_W    = DIN_W_DEF,
    parameter int ACT_BITS = 8,
    localparam int ACC_W   = acc_w(N_BANKS, DIN_W, ACT_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [N_BANKS*DIN_W-1:0] in_data,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic                     in_neg,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_sum
);

    localparam int LEVELS = clog2(N_BANKS);
    localparam int TREE_W = tree_w(N_BANKS, DIN_W);
    localparam int EXT_W  = ACC_W - TREE_W;

    logic [N_BANKS*DIN_W-1:0] data_q;
    beat_ctl_t                ctl0_q;
    beat_ctl_t                ctl [0:LEVELS];
    // Heap layout: root at 1, leaves at N_BANKS..2*N_BANKS-1.
    logic [TREE_W-1:0]        node [1:2*N_BANKS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ctl0_q <= '0;
        end else begin
            data_q       <= in_data;
            ctl0_q.valid <= in_valid;
            ctl0_q.first <= in_valid & in_first;
            ctl0_q.last  <= in_valid & in_last;
            ctl0_q.neg   <= in_valid & in_neg;
        end
    end

    assign ctl[0] = ctl0_q;

    for (genvar i = 0; i < N_BANKS; i++) begin : g_leaf
        assign node[N_BANKS+i] = {{LEVELS{1'b0}}, data_q[i*DIN_W +: DIN_W]};
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        for (genvar k = N_BANKS >> l; k < (N_BANKS >> (l - 1)); k++) begin : g_node
            logic [TREE_W-1:0] s;

            adder_nbit #(
                .W(TREE_W)
            ) u_add (
                .a  (node[2*k]),
                .b  (node[2*k+1]),
                .sum(s)
            );

`ifdef CIM_TREE_PIPE_EN
            logic [TREE_W-1:0] s_q;

            always_ff @(posedge clk) begin
                if (rst) s_q <= '0;
                else     s_q <= s;
            end

            assign node[k] = s_q;
`else
            assign node[k] = s;
`endif
        end

`ifdef CIM_TREE_PIPE_EN
        beat_ctl_t ctl_q;

        always_ff @(posedge clk) begin
            if (rst) ctl_q <= '0;
            else     ctl_q <= ctl[l-1];
        end

        assign ctl[l] = ctl_q;
`else
        assign ctl[l] = ctl[l-1];
`endif
    end

    beat_ctl_t                c;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  ext;

    assign c = ctl[LEVELS];

    always_comb begin
        ext      = {{EXT_W{1'b0}}, node[1]};
        base     = c.first ? '0 : (acc << 1);
        acc_next = c.neg ? (base - ext) : (base + ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= c.valid & c.last;
            if (c.valid) begin
                acc <= acc_next;
                if (c.last) out_sum <= acc_next;
            end
        end
    end

endmodule
